// File: rtl/messbauer_saw_tooth_generator.sv
// Velocity-reference ramp generator for the Mossbauer drive DAC: prescaled channel counter with registered code/direction/start.
// Define MESSBAUER_SAW_TOOTH_REVERSE_SLOPE_EN for triangle mode (512 channels); default build is a 256-channel sawtooth.
module messbauer_saw_tooth_generator #(
  parameter int unsigned CLOCK_DIVIDER = 1
) (
  input  logic       clk,
  input  logic       areset,
  output logic [7:0] out_value,
  output logic [8:0] channel,
  output logic       direction,
  output logic       start
);

`ifdef MESSBAUER_SAW_TOOTH_REVERSE_SLOPE_EN
  localparam logic [8:0] LAST_CH = 9'd511;
`else
  localparam logic [8:0] LAST_CH = 9'd255;
`endif

  localparam logic [15:0] PCNT_MAX = 16'(CLOCK_DIVIDER - 1);

  logic [15:0] pcnt_q, pcnt_d;
  logic [8:0]  channel_q, channel_d;
  logic [7:0]  out_q, out_d;
  logic        dir_q, dir_d;
  logic        start_q, start_d;
  logic        tick;
  logic        wrap;

  assign tick = (pcnt_q == PCNT_MAX);
  assign wrap = (channel_q == LAST_CH);

  always_comb begin
    pcnt_d    = pcnt_q + 16'd1;
    channel_d = channel_q;
    start_d   = 1'b0;
    if (tick) begin
      pcnt_d  = '0;
      start_d = wrap;
      if (wrap) begin
        channel_d = '0;
      end else begin
        channel_d = channel_q + 9'd1;
      end
    end
  end

  // Code and direction derive from the next channel so they land in the same edge as the channel itself.
  always_comb begin
`ifdef MESSBAUER_SAW_TOOTH_REVERSE_SLOPE_EN
    out_d = channel_d[8] ? ~channel_d[7:0] : channel_d[7:0];
    dir_d = channel_d[8];
`else
    out_d = channel_d[7:0];
    dir_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pcnt_q    <= '0;
      channel_q <= '0;
      out_q     <= '0;
      dir_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      channel_q <= channel_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      start_q   <= start_d;
    end
  end

  assign out_value = out_q;
  assign channel   = channel_q;
  assign direction = dir_q;
  assign start     = start_q;

endmodule

// File: tb/tb_messbauer_saw_tooth_generator.sv
// Bench for messbauer_saw_tooth_generator: dividers 1, 4 and 65535 run side by side against a cycle-count model.
module tb_messbauer_saw_tooth_generator;

`ifdef MESSBAUER_SAW_TOOTH_REVERSE_SLOPE_EN
  localparam int unsigned N = 512;
  localparam bit TRI = 1'b1;
  localparam int unsigned MID_CH = 300;
`else
  localparam int unsigned N = 256;
  localparam bit TRI = 1'b0;
  localparam int unsigned MID_CH = 200;
`endif

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic [7:0] ov1, ov4, ov64;
  logic [8:0] ch1, ch4, ch64;
  logic       dr1, dr4, dr64;
  logic       st1, st4, st64;

  int unsigned tests = 0;
  int unsigned failures = 0;
  int unsigned k = 0;

  always #5 clk = ~clk;

  messbauer_saw_tooth_generator #(.CLOCK_DIVIDER(1)) u_div1 (
    .clk(clk), .areset(areset), .out_value(ov1), .channel(ch1), .direction(dr1), .start(st1));
  messbauer_saw_tooth_generator #(.CLOCK_DIVIDER(4)) u_div4 (
    .clk(clk), .areset(areset), .out_value(ov4), .channel(ch4), .direction(dr4), .start(st4));
  messbauer_saw_tooth_generator #(.CLOCK_DIVIDER(65535)) u_div64k (
    .clk(clk), .areset(areset), .out_value(ov64), .channel(ch64), .direction(dr64), .start(st64));

  typedef struct {
    int unsigned k;
    bit          sel4;
    logic [8:0]  ch;
    logic [7:0]  val;
    logic        dir;
    logic        st;
  } vec_t;

  vec_t vecs[$];

  function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at k=%0d: got %0d, expected %0d", name, k, act, exp);
    end
  endfunction

  function automatic void check_model(string tag, int unsigned d, logic [7:0] ov,
                                      logic [8:0] ch, logic dir, logic st);
    int unsigned e_ch;
    logic [8:0]  ech9;
    logic [7:0]  e_out;
    logic        e_dir;
    logic        e_st;
    e_ch  = (k / d) % N;
    ech9  = 9'(e_ch);
    e_dir = TRI ? ech9[8] : 1'b0;
    e_out = (TRI && ech9[8]) ? ~ech9[7:0] : ech9[7:0];
    e_st  = (k != 0) && ((k % (d * N)) == 0);
    cmp({tag, ".channel"}, 32'(ch), 32'(ech9));
    cmp({tag, ".out_value"}, 32'(ov), 32'(e_out));
    cmp({tag, ".direction"}, 32'(dir), 32'(e_dir));
    cmp({tag, ".start"}, 32'(st), 32'(e_st));
  endfunction

  function automatic void check_zero(string tag, logic [7:0] ov, logic [8:0] ch,
                                     logic dir, logic st);
    cmp({tag, ".rst_out_value"}, 32'(ov), 32'd0);
    cmp({tag, ".rst_channel"}, 32'(ch), 32'd0);
    cmp({tag, ".rst_direction"}, 32'(dir), 32'd0);
    cmp({tag, ".rst_start"}, 32'(st), 32'd0);
  endfunction

  function automatic void check_all_zero();
    check_zero("div1", ov1, ch1, dr1, st1);
    check_zero("div4", ov4, ch4, dr4, st4);
    check_zero("div65535", ov64, ch64, dr64, st64);
    cmp("div65535.rst_pcnt", 32'(u_div64k.pcnt_q), 32'd0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    check_model("div1", 1, ov1, ch1, dr1, st1);
    check_model("div4", 4, ov4, ch4, dr4, st4);
    check_model("div65535", 65535, ov64, ch64, dr64, st64);
    cmp("div65535.pcnt_bound", 32'(u_div64k.pcnt_q <= 16'd65534), 32'd1);
  endtask

  initial begin
`ifdef MESSBAUER_SAW_TOOTH_REVERSE_SLOPE_EN
    vecs.push_back('{0,    1'b0, 9'd0,   8'd0,   1'b0, 1'b0});
    vecs.push_back('{1,    1'b0, 9'd1,   8'd1,   1'b0, 1'b0});
    vecs.push_back('{3,    1'b1, 9'd0,   8'd0,   1'b0, 1'b0});
    vecs.push_back('{4,    1'b1, 9'd1,   8'd1,   1'b0, 1'b0});
    vecs.push_back('{255,  1'b0, 9'd255, 8'd255, 1'b0, 1'b0});
    vecs.push_back('{256,  1'b0, 9'd256, 8'd255, 1'b1, 1'b0});
    vecs.push_back('{257,  1'b0, 9'd257, 8'd254, 1'b1, 1'b0});
    vecs.push_back('{511,  1'b0, 9'd511, 8'd0,   1'b1, 1'b0});
    vecs.push_back('{512,  1'b0, 9'd0,   8'd0,   1'b0, 1'b1});
    vecs.push_back('{513,  1'b0, 9'd1,   8'd1,   1'b0, 1'b0});
    vecs.push_back('{1023, 1'b1, 9'd255, 8'd255, 1'b0, 1'b0});
    vecs.push_back('{1024, 1'b1, 9'd256, 8'd255, 1'b1, 1'b0});
    vecs.push_back('{2048, 1'b1, 9'd0,   8'd0,   1'b0, 1'b1});
    vecs.push_back('{2049, 1'b1, 9'd0,   8'd0,   1'b0, 1'b0});
`else
    vecs.push_back('{0,    1'b0, 9'd0,   8'd0,   1'b0, 1'b0});
    vecs.push_back('{1,    1'b0, 9'd1,   8'd1,   1'b0, 1'b0});
    vecs.push_back('{3,    1'b1, 9'd0,   8'd0,   1'b0, 1'b0});
    vecs.push_back('{4,    1'b1, 9'd1,   8'd1,   1'b0, 1'b0});
    vecs.push_back('{255,  1'b0, 9'd255, 8'd255, 1'b0, 1'b0});
    vecs.push_back('{256,  1'b0, 9'd0,   8'd0,   1'b0, 1'b1});
    vecs.push_back('{257,  1'b0, 9'd1,   8'd1,   1'b0, 1'b0});
    vecs.push_back('{1023, 1'b1, 9'd255, 8'd255, 1'b0, 1'b0});
    vecs.push_back('{1024, 1'b1, 9'd0,   8'd0,   1'b0, 1'b1});
    vecs.push_back('{1025, 1'b1, 9'd0,   8'd0,   1'b0, 1'b0});
`endif

    // Reset held across several edges: everything stays at zero.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_all_zero();
    end
    #3 areset = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) step();

    // Reset asserted between edges must clear outputs before the next edge.
    #2 areset = 1'b1;
    #1 check_all_zero();
    @(posedge clk);
    #1 check_all_zero();
    #2 areset = 1'b0;
    k = 0;

    foreach (vecs[i]) begin
      while (k < vecs[i].k) step();
      if (vecs[i].sel4) begin
        cmp("vec.div4.channel", 32'(ch4), 32'(vecs[i].ch));
        cmp("vec.div4.out_value", 32'(ov4), 32'(vecs[i].val));
        cmp("vec.div4.direction", 32'(dr4), 32'(vecs[i].dir));
        cmp("vec.div4.start", 32'(st4), 32'(vecs[i].st));
      end else begin
        cmp("vec.div1.channel", 32'(ch1), 32'(vecs[i].ch));
        cmp("vec.div1.out_value", 32'(ov1), 32'(vecs[i].val));
        cmp("vec.div1.direction", 32'(dr1), 32'(vecs[i].dir));
        cmp("vec.div1.start", 32'(st1), 32'(vecs[i].st));
      end
    end

    // Maximum divider: channel 0 lasts 65535 edges, then steps to 1.
    while (k < 65534) step();
    cmp("div65535.hold_ch0", 32'(ch64), 32'd0);
    cmp("div65535.pcnt_top", 32'(u_div64k.pcnt_q), 32'd65534);
    step();
    cmp("div65535.adv_ch1", 32'(ch64), 32'd1);
    cmp("div65535.adv_out1", 32'(ov64), 32'd1);
    cmp("div65535.pcnt_wrap", 32'(u_div64k.pcnt_q), 32'd0);
    for (int i = 0; i < 5; i++) step();

    // Mid-ramp reset, then a clean restart with no start strobe until the next wrap.
    while ((k % N) != MID_CH) step();
    cmp("mid.div1.channel", 32'(ch1), 32'(MID_CH));
    cmp("mid.div1.direction", 32'(dr1), 32'(TRI));
    #2 areset = 1'b1;
    #1 check_all_zero();
    @(posedge clk);
    #1 check_all_zero();
    #2 areset = 1'b0;
    k = 0;
    for (int unsigned i = 0; i < N + 2; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
